// File: rtl/fp_div_ctrl.sv
// rtl/fp_div_ctrl.sv - request/response front-end for the FP divider
// Holds operands on fp_div, waits for a qualified done or timeout, keeps sticky fflags.
module fp_div_ctrl #(
  parameter int W       = 32,
  parameter int MIN_LAT = 3,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [2:0]   req_rm,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [4:0]   res_flags,
  output logic         res_timeout,
  output logic [W-1:0] div_in1,
  output logic [W-1:0] div_in2,
  output logic [2:0]   div_round_m,
  output logic         div_act,
  input  logic [W-1:0] div_out,
  input  logic         div_done,
  input  logic         div_ov,
  input  logic         div_un,
  input  logic         div_inv,
  input  logic         div_zero,
  input  logic         div_inexact,
  output logic [4:0]   fflags,
  input  logic         fflags_clr,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CW-1:0] MIN_C = CW'(MIN_LAT);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT - 1);
  localparam logic [W-1:0]  QNAN  = W'(32'h7FC0_0000);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          done_ok, tmo, capture;
  logic [4:0]    new_flags;

  always_comb begin
    state_nx = state;
    done_ok  = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE:  if (req_valid) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        // a done seen before MIN_LAT belongs to a previous operation
        done_ok = div_done && (cnt >= MIN_C);
        tmo     = !done_ok && (cnt == TMO_C);
        if (done_ok || tmo) state_nx = RESP;
      end
      RESP:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign capture   = done_ok || tmo;
  assign new_flags = tmo ? 5'b10000 : {div_inv, div_zero, div_ov, div_un, div_inexact};

  assign req_ready = (state == IDLE);
  assign res_valid = (state == RESP);
  assign div_act   = (state == ISSUE) || (state == WAIT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_in1     <= '0;
      div_in2     <= '0;
      div_round_m <= '0;
      res_data    <= '0;
      res_flags   <= '0;
      res_timeout <= 1'b0;
      fflags      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        div_in1     <= req_a;
        div_in2     <= req_b;
        div_round_m <= req_rm;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + CW'(1);
      if (capture) begin
        res_data    <= tmo ? QNAN : div_out;
        res_flags   <= new_flags;
        res_timeout <= tmo;
        // clear takes effect before this operation's flags are merged
        fflags      <= (fflags_clr ? 5'b00000 : fflags) | new_flags;
      end else if (fflags_clr) begin
        fflags <= '0;
      end
    end
  end

endmodule
